// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder-buffer control slice.
// Pointers carry one extra wrap bit above the entry index.
package rob_pkg;

  localparam int ROB_ENTRIES = 128;
  localparam int IDX_W       = $clog2(ROB_ENTRIES);
  localparam int PTR_W       = IDX_W + 1;

  typedef logic [PTR_W-1:0] rob_ptr_t;
  typedef logic [IDX_W-1:0] rob_idx_t;

  typedef enum logic [2:0] {
    READY     = 3'd0,
    ISSUED    = 3'd1,
    DONE      = 3'd2,
    EXCEPTION = 3'd3,
    INTERRUPT = 3'd4,
    TRAP      = 3'd5
  } status_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  // Natural overflow of the wrap bit gives modulo 2*ROB_ENTRIES.
  function automatic rob_ptr_t ptr_inc(input rob_ptr_t p);
    return p + rob_ptr_t'(1'b1);
  endfunction

endpackage

// File: rtl/rob_status_array.sv
// Per-entry valid bit and status for the reorder buffer.
// Applies allocate/issue/writeback/retire updates and exposes the head entry.
module rob_status_array
  import rob_pkg::*;
#(
  parameter int ENTRIES  = ROB_ENTRIES,
  parameter int WB_PORTS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_clear,
  input  logic                            alloc_en,
  input  rob_idx_t                        alloc_idx,
  input  logic                            issue_en,
  input  rob_idx_t                        issue_idx,
  input  logic [WB_PORTS-1:0]             wb_en,
  input  logic [WB_PORTS-1:0][IDX_W-1:0]  wb_idx,
  input  logic [WB_PORTS-1:0]             wb_exc,
  input  logic                            retire_en,
  input  rob_idx_t                        head_idx,
  output logic                            head_valid,
  output status_t                         head_status
);

  logic [ENTRIES-1:0] valid_r;
  logic [ENTRIES-1:0] valid_nxt_s;
  logic [ENTRIES-1:0] wb_hit_s;
  logic [ENTRIES-1:0] exc_hit_s;
  status_t            status_r   [ENTRIES];
  status_t            status_nxt_s [ENTRIES];

  // Merge all writeback ports per entry; any exception strobe dominates.
  always_comb begin
    wb_hit_s  = '0;
    exc_hit_s = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_hit_s[wb_idx[p]]  = wb_hit_s[wb_idx[p]] | wb_en[p];
      exc_hit_s[wb_idx[p]] = exc_hit_s[wb_idx[p]] | (wb_en[p] & wb_exc[p]);
    end
  end

  // Next-state per entry: flush > retire > allocate > writeback > issue.
  always_comb begin
    valid_nxt_s = valid_r;
    for (int i = 0; i < ENTRIES; i++) begin
      status_nxt_s[i] = status_r[i];
      if (flush_clear) begin
        valid_nxt_s[i] = 1'b0;
      end else if (retire_en && (head_idx == rob_idx_t'(i))) begin
        valid_nxt_s[i] = 1'b0;
      end else if (alloc_en && (alloc_idx == rob_idx_t'(i))) begin
        valid_nxt_s[i]  = 1'b1;
        status_nxt_s[i] = READY;
      end else if (valid_r[i] && wb_hit_s[i]) begin
        status_nxt_s[i] = exc_hit_s[i] ? EXCEPTION : DONE;
      end else if (valid_r[i] && issue_en && (issue_idx == rob_idx_t'(i))
                   && (status_r[i] == READY)) begin
        status_nxt_s[i] = ISSUED;
      end else begin
        valid_nxt_s[i] = valid_r[i];
      end
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      for (int i = 0; i < ENTRIES; i++) status_r[i] <= READY;
    end else begin
      valid_r <= valid_nxt_s;
      for (int i = 0; i < ENTRIES; i++) status_r[i] <= status_nxt_s[i];
    end
  end

  assign head_valid  = valid_r[head_idx];
  assign head_status = status_r[head_idx];

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/status controller: in-order allocate and retire,
// with a one-cycle flush sequenced when the head entry has faulted.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int ROB_ENTRIES = rob_pkg::ROB_ENTRIES,
  parameter int WB_PORTS    = 2,
  parameter int PTR_W       = $clog2(ROB_ENTRIES) + 1
) (
  input  logic                             clk_in,
  input  logic                             rst_N_in,
  input  logic                             dispatch_valid_in,
  output logic                             dispatch_ready_out,
  output logic [PTR_W-1:0]                 dispatch_ptr_out,
  input  logic                             issue_valid_in,
  input  logic [PTR_W-2:0]                 issue_ptr_in,
  input  logic [WB_PORTS-1:0]              wb_valid_in,
  input  logic [WB_PORTS-1:0][PTR_W-2:0]   wb_ptr_in,
  input  logic [WB_PORTS-1:0]              wb_exc_in,
  output logic                             commit_valid_out,
  input  logic                             commit_ready_in,
  output logic [PTR_W-2:0]                 commit_ptr_out,
  output logic                             exc_valid_out,
  output logic                             flush_out,
  output logic [PTR_W-1:0]                 count_out,
  output logic                             full_out,
  output logic                             empty_out
);

  rob_ptr_t    head_r, tail_r, count_r;
  rob_ptr_t    head_nxt_s, tail_nxt_s, count_nxt_s;
  ctrl_state_t state_r, state_nxt_s;
  logic        run_s, full_s, head_valid_s, exc_s;
  logic        dispatch_fire_s, commit_fire_s, commit_valid_s;
  status_t     head_status_s;

  assign run_s  = (state_r == RUN);
  assign full_s = (head_r[PTR_W-2:0] == tail_r[PTR_W-2:0]) && (head_r[PTR_W-1] != tail_r[PTR_W-1]);
  assign exc_s  = run_s && head_valid_s && (head_status_s == EXCEPTION);
  assign commit_valid_s  = run_s && head_valid_s && (head_status_s == DONE);
  // Dispatch is held off for the exception-detect cycle so nothing lands behind a fault.
  assign dispatch_ready_out = run_s && !full_s && !exc_s;
  assign dispatch_fire_s    = dispatch_valid_in && dispatch_ready_out;
  assign commit_fire_s      = commit_valid_s && commit_ready_in;

  rob_status_array #(
    .ENTRIES  (ROB_ENTRIES),
    .WB_PORTS (WB_PORTS)
  ) u_status (
    .clk         (clk_in),
    .rst_n       (rst_N_in),
    .flush_clear (!run_s),
    .alloc_en    (dispatch_fire_s),
    .alloc_idx   (tail_r[PTR_W-2:0]),
    .issue_en    (issue_valid_in && run_s),
    .issue_idx   (issue_ptr_in),
    .wb_en       (wb_valid_in & {WB_PORTS{run_s}}),
    .wb_idx      (wb_ptr_in),
    .wb_exc      (wb_exc_in),
    .retire_en   (commit_fire_s),
    .head_idx    (head_r[PTR_W-2:0]),
    .head_valid  (head_valid_s),
    .head_status (head_status_s)
  );

  // Pointer, occupancy and run/flush sequencing.
  always_comb begin
    state_nxt_s = state_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    case (state_r)
      RUN: begin
        if (exc_s) state_nxt_s = FLUSH;
        else       state_nxt_s = RUN;
        head_nxt_s  = commit_fire_s   ? ptr_inc(head_r) : head_r;
        tail_nxt_s  = dispatch_fire_s ? ptr_inc(tail_r) : tail_r;
        count_nxt_s = count_r + rob_ptr_t'(dispatch_fire_s) - rob_ptr_t'(commit_fire_s);
      end
      FLUSH: begin
        // Skip past the faulting entry and restart empty.
        state_nxt_s = RUN;
        head_nxt_s  = ptr_inc(head_r);
        tail_nxt_s  = ptr_inc(head_r);
        count_nxt_s = '0;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_r <= RUN;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign dispatch_ptr_out = tail_r;
  assign commit_valid_out = commit_valid_s;
  assign commit_ptr_out   = head_r[PTR_W-2:0];
  assign exc_valid_out    = exc_s;
  assign flush_out        = (state_r == FLUSH);
  assign count_out        = count_r;
  assign full_out         = full_s;
  assign empty_out        = (head_r == tail_r);

endmodule
